// File: rtl/firebird7_in_gate1_tessent_tdr_len_w3.sv
// IJTAG test data register that feeds a select bit and a WIDTH-bit data word to a downstream mux.
// A sticky length_error flag reports whether the last update followed a shift of the wrong length.
module firebird7_in_gate1_tessent_tdr_len_w3 #(
    parameter int WIDTH = 3
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] capture_data_in,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             length_error
);

    localparam int L  = WIDTH + 2;
    localparam int CW = $clog2(L + 2);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LEN  = CW'(L);
    localparam logic [CW-1:0] CNT_SAT  = CW'(L + 1);

    logic [L-1:0]     sr_r;
    logic [L-1:0]     sr_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic             select_r;
    logic             select_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_s;
    logic             err_r;
    logic             err_s;

    // Next-state selection: capture beats shift beats update, and nothing acts while deselected.
    always_comb begin
        sr_s     = sr_r;
        cnt_s    = cnt_r;
        select_s = select_r;
        data_s   = data_r;
        err_s    = err_r;
        if (!ijtag_sel) begin
            sr_s = sr_r;
        end else if (ijtag_ce) begin
            sr_s  = {err_r, capture_data_in, select_r};
            cnt_s = CNT_ZERO;
        end else if (ijtag_se) begin
            sr_s = {ijtag_si, sr_r[L-1:1]};
            // Saturate one past the legal length so an over-long shift can never wrap back to L.
            if (cnt_r != CNT_SAT) begin
                cnt_s = cnt_r + CNT_ONE;
            end else begin
                cnt_s = cnt_r;
            end
        end else if (ijtag_ue) begin
            cnt_s = CNT_ZERO;
            if (cnt_r == CNT_LEN) begin
                select_s = sr_r[0];
                data_s   = sr_r[WIDTH:1];
                err_s    = 1'b0;
            end else begin
                err_s = 1'b1;
            end
        end else begin
            sr_s = sr_r;
        end
    end

    // State registers with synchronous reset taking precedence over every scan operation.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            sr_r     <= {L{1'b0}};
            cnt_r    <= CNT_ZERO;
            select_r <= 1'b0;
            data_r   <= {WIDTH{1'b0}};
            err_r    <= 1'b0;
        end else begin
            sr_r     <= sr_s;
            cnt_r    <= cnt_s;
            select_r <= select_s;
            data_r   <= data_s;
            err_r    <= err_s;
        end
    end

    assign ijtag_so       = sr_r[0];
    assign ijtag_select   = select_r;
    assign ijtag_data_out = data_r;
    assign length_error   = err_r;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_len_w3.sv
// Directed bench for the length-checked IJTAG TDR with WIDTH=3 (scan length 5).
module tb_firebird7_in_gate1_tessent_tdr_len_w3;

    logic       ijtag_tck = 1'b0;
    logic       ijtag_reset;
    logic       ijtag_sel;
    logic       ijtag_ce;
    logic       ijtag_se;
    logic       ijtag_ue;
    logic       ijtag_si;
    logic       ijtag_so;
    logic [2:0] capture_data_in;
    logic       ijtag_select;
    logic [2:0] ijtag_data_out;
    logic       length_error;

    int n_cmp = 0;
    int n_err = 0;

    firebird7_in_gate1_tessent_tdr_len_w3 #(.WIDTH(3)) dut (
        .ijtag_tck       (ijtag_tck),
        .ijtag_reset     (ijtag_reset),
        .ijtag_sel       (ijtag_sel),
        .ijtag_ce        (ijtag_ce),
        .ijtag_se        (ijtag_se),
        .ijtag_ue        (ijtag_ue),
        .ijtag_si        (ijtag_si),
        .ijtag_so        (ijtag_so),
        .capture_data_in (capture_data_in),
        .ijtag_select    (ijtag_select),
        .ijtag_data_out  (ijtag_data_out),
        .length_error    (length_error)
    );

    always #5 ijtag_tck = ~ijtag_tck;

    task automatic tick(input logic c, input logic s, input logic u, input logic i);
        ijtag_ce = c;
        ijtag_se = s;
        ijtag_ue = u;
        ijtag_si = i;
        @(posedge ijtag_tck);
        #1;
        ijtag_ce = 1'b0;
        ijtag_se = 1'b0;
        ijtag_ue = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic sel_e, input logic [2:0] data_e, input logic err_e);
        chk({tag, "_select"}, {31'd0, ijtag_select}, {31'd0, sel_e});
        chk({tag, "_data"}, {29'd0, ijtag_data_out}, {29'd0, data_e});
        chk({tag, "_err"}, {31'd0, length_error}, {31'd0, err_e});
    endtask

    task automatic chk_so(input string tag, input logic exp);
        chk(tag, {31'd0, ijtag_so}, {31'd0, exp});
    endtask

    initial begin
        ijtag_reset     = 1'b1;
        ijtag_sel       = 1'b0;
        ijtag_ce        = 1'b0;
        ijtag_se        = 1'b0;
        ijtag_ue        = 1'b0;
        ijtag_si        = 1'b0;
        capture_data_in = 3'b000;

        // Reset state
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        ijtag_reset = 1'b0;
        chk_so("rst_so", 1'b0);
        chk_out("rst", 1'b0, 3'b000, 1'b0);

        // Capture {0,101,0} and shift out: 0,1,0,1,0
        ijtag_sel       = 1'b1;
        capture_data_in = 3'b101;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk_so("cap_so0", 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk_so("cap_so1", 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk_so("cap_so2", 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk_so("cap_so3", 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk_so("cap_so4", 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk_so("cap_so5", 1'b0);

        // Correct-length load: shift 1,0,1,1,0 -> select=1, data=110
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk_out("preupd", 1'b0, 3'b000, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("upd_ok", 1'b1, 3'b110, 1'b0);

        // Short shift (4) -> outputs hold, flag set
        capture_data_in = 3'b000;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("short", 1'b1, 3'b110, 1'b1);

        // Capture now holds status=1 at the top: {1,000,1}; the fifth bit out is 1
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk_so("stat_so0", 1'b1);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk_so("stat_so3", 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk_so("stat_so4", 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);

        // Correct-length update clears the flag: shift 0,1,1,0,0 -> select=0, data=011
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("clear", 1'b0, 3'b011, 1'b0);

        // Over-long shifts: 7 and 13 both flag (counter saturates, never wraps to 5)
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("long7", 1'b0, 3'b011, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++) tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("long13", 1'b0, 3'b011, 1'b1);

        // Deselected pulses are ignored mid-shift: capture {1,100,0}, shift 1,1,0
        capture_data_in = 3'b100;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        chk_so("mid_so1", 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk_so("mid_so3", 1'b1);
        ijtag_sel = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk_so("nosel_ce", 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk_so("nosel_se", 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("nosel_ue", 1'b0, 3'b011, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        chk_so("nosel_all", 1'b1);
        chk_out("nosel_all", 1'b0, 3'b011, 1'b1);
        // Two more shifts complete the 5-bit count: bits 1,1,0,0,1 -> select=1, data=001
        ijtag_sel = 1'b1;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("resume", 1'b1, 3'b001, 1'b0);

        // ce+se together: capture only -> {0,010,1}, so reads 1,0,1
        capture_data_in = 3'b010;
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        chk_so("cese_so0", 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk_so("cese_so1", 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk_so("cese_so2", 1'b1);

        // Reset mid-shift overrides ce, then an update without a fresh shift flags an error
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        ijtag_reset = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        ijtag_reset = 1'b0;
        chk_so("rst2_so", 1'b0);
        chk_out("rst2", 1'b0, 3'b000, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("rst2_upd", 1'b0, 3'b000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
